// File: rtl/unidade_mult_div_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// master = ALU side issuing operations, slave = the unit itself.
interface unidade_mult_div_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             mult_overflow;
  logic             div_error;

  modport master (
    output start, op, A, B,
    input  busy, done, result, remainder, mult_overflow, div_error
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, remainder, mult_overflow, div_error
  );
endinterface

// File: rtl/unidade_mult_div.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// A single 2*WIDTH accumulator is shared: {product} for multiply, {remainder, quotient} for divide.
module unidade_mult_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unidade_mult_div_if.slave     bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpDiv = 3'b110;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_acc;
  logic [2*WIDTH-1:0] step_acc;

  // One iteration of each algorithm, computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    div_acc   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
    step_acc  = is_div_q ? div_acc : mul_acc;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.op == OpMul || (bus.op == OpDiv && bus.B != '0)) begin
            is_div_d = (bus.op == OpDiv);
            opnd_d   = (bus.op == OpDiv) ? bus.B : bus.A;
            acc_d    = {{WIDTH{1'b0}}, ((bus.op == OpDiv) ? bus.A : bus.B)};
            cnt_d    = CntW'(WIDTH);
            state_d  = StRun;
          end else if (bus.op == OpDiv) begin
            // Divide by zero completes immediately without iterating.
            result_d = '1;
            rem_d    = bus.A;
            ovf_d    = 1'b0;
            err_d    = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StRun: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = step_acc[WIDTH-1:0];
          rem_d    = is_div_q ? step_acc[2*WIDTH-1:WIDTH] : '0;
          ovf_d    = is_div_q ? 1'b0 : (|step_acc[2*WIDTH-1:WIDTH]);
          err_d    = 1'b0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy          = (state_q == StRun);
  assign bus.done          = (state_q == StDone);
  assign bus.result        = result_q;
  assign bus.remainder     = rem_q;
  assign bus.mult_overflow = ovf_q;
  assign bus.div_error     = err_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed, table-driven bench for unidade_mult_div (WIDTH = 8).
module tb_unidade_mult_div;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   overlap;

  unidade_mult_div_if #(.WIDTH(8)) bus ();

  unidade_mult_div #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [7:0] rem;
    logic       ovf;
    logic       err;
    int         done_at;
    int         busy_n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge, then watch 12 cycles (sample k follows edge k).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output int busy_n, output int done_at, output int done_n);
    busy_n  = 0;
    done_at = -1;
    done_n  = 0;
    bus.A     = a;
    bus.B     = b;
    bus.op    = op;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (bus.busy && bus.done) overlap++;
    end
  endtask

  initial begin
    int busy_n, done_at, done_n;
    total   = 0;
    bad     = 0;
    overlap = 0;

    vecs[0] = '{8'd15,  8'd17,  3'b101, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 8};
    vecs[1] = '{8'd16,  8'd16,  3'b101, 8'h00, 8'h00, 1'b1, 1'b0, 8, 8};
    vecs[2] = '{8'd0,   8'd255, 3'b101, 8'h00, 8'h00, 1'b0, 1'b0, 8, 8};
    vecs[3] = '{8'd200, 8'd7,   3'b110, 8'd28, 8'd4,  1'b0, 1'b0, 8, 8};
    vecs[4] = '{8'd255, 8'd1,   3'b110, 8'd255, 8'd0, 1'b0, 1'b0, 8, 8};
    vecs[5] = '{8'h2A,  8'd0,   3'b110, 8'hFF, 8'h2A, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{8'd13,  8'd20,  3'b101, 8'h04, 8'h00, 1'b1, 1'b0, 8, 8};
    vecs[7] = '{8'd5,   8'd9,   3'b110, 8'd0,  8'd5,  1'b0, 1'b0, 8, 8};
    vecs[8] = '{8'd100, 8'd10,  3'b110, 8'd10, 8'd0,  1'b0, 1'b0, 8, 8};
    vecs[9] = '{8'd255, 8'd255, 3'b101, 8'h01, 8'h00, 1'b1, 1'b0, 8, 8};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b0;
    #1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset result", {24'b0, bus.result}, 32'd0);
    chk("reset remainder", {24'b0, bus.remainder}, 32'd0);
    chk("reset ovf", {31'b0, bus.mult_overflow}, 32'd0);
    chk("reset err", {31'b0, bus.div_error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, busy_n, done_at, done_n);
      chk($sformatf("v%0d result", i), {24'b0, bus.result}, {24'b0, vecs[i].res});
      chk($sformatf("v%0d remainder", i), {24'b0, bus.remainder}, {24'b0, vecs[i].rem});
      chk($sformatf("v%0d ovf", i), {31'b0, bus.mult_overflow}, {31'b0, vecs[i].ovf});
      chk($sformatf("v%0d err", i), {31'b0, bus.div_error}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d done_at", i), done_at, vecs[i].done_at);
      chk($sformatf("v%0d busy_cycles", i), busy_n, vecs[i].busy_n);
      chk($sformatf("v%0d done_pulses", i), done_n, 32'd1);
    end

    // 12*11 = 132; operands change and start is re-asserted during RUN and DONE.
    busy_n  = 0;
    done_at = -1;
    done_n  = 0;
    bus.A = 8'd12;
    bus.B = 8'd11;
    bus.op = 3'b101;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == 2) begin
        bus.A = 8'd255;
        bus.B = 8'd255;
        bus.start = 1'b1;
      end
      if (k == 9) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (bus.busy && bus.done) overlap++;
    end
    chk("held result", {24'b0, bus.result}, 32'd132);
    chk("held ovf", {31'b0, bus.mult_overflow}, 32'd0);
    chk("held done_at", done_at, 32'd8);
    chk("held busy_cycles", busy_n, 32'd8);
    chk("held done_pulses", done_n, 32'd1);

    // Unsupported op in IDLE: nothing happens, outputs hold.
    run_op(8'd7, 8'd3, 3'b011, busy_n, done_at, done_n);
    chk("badop busy_cycles", busy_n, 32'd0);
    chk("badop done_pulses", done_n, 32'd0);
    chk("badop result hold", {24'b0, bus.result}, 32'd132);

    // Reset in the middle of a multiply.
    bus.A = 8'd200;
    bus.B = 8'd200;
    bus.op = 3'b101;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrun busy before reset", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort done", {31'b0, bus.done}, 32'd0);
    chk("abort result", {24'b0, bus.result}, 32'd0);
    chk("abort remainder", {24'b0, bus.remainder}, 32'd0);
    chk("abort ovf", {31'b0, bus.mult_overflow}, 32'd0);
    chk("abort err", {31'b0, bus.div_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
    end
    chk("after abort done_pulses", done_n, 32'd0);
    chk("after abort busy_cycles", busy_n, 32'd0);

    run_op(8'd3, 8'd5, 3'b101, busy_n, done_at, done_n);
    chk("post-reset result", {24'b0, bus.result}, 32'd15);
    chk("post-reset ovf", {31'b0, bus.mult_overflow}, 32'd0);
    chk("post-reset done_at", done_at, 32'd8);
    chk("post-reset done_pulses", done_n, 32'd1);

    chk("busy/done overlap", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
